muldiv: RTL and testbench

- Iterative multiply/divide unit with HI/LO result registers, for the next-generation pipelined CPU (MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI/MTLO).
- Sits beside the ALU in the execute stage. The CPU launches an operation with a start pulse and stalls any MFHI/MFLO while busy is high.
- Operand width is parametrised. It uses a radix-2 shift-add / restoring-division datapath, one bit per cycle.

---
 rtl/muldiv.sv | 135 +++++++++++++
 tb/tb_muldiv.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with sign handled by magnitude + final correction.
module muldiv #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  acc;      // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [W-1:0]    opnd;     // multiplicand magnitude or divisor magnitude
  logic            is_div;
  logic            neg_q;    // product / quotient must be negated
  logic            neg_r;    // remainder must be negated

  logic            sgn;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      mul_sum;
  logic [W:0]      rem_sh;
  logic [W-1:0]    rem_diff;
  logic            rem_ge;
  logic [2*W-1:0]  acc_step;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix;
  logic [W-1:0]    rem_fix;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    sgn      = ~op[0];
    mag_a    = (sgn && a[W-1]) ? -a : a;
    mag_b    = (sgn && b[W-1]) ? -b : b;

    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    rem_sh   = acc[2*W-1:W-1];
    rem_ge   = (rem_sh >= {1'b0, opnd});
    // Modulo-2^W difference is exact whenever the trial subtraction succeeds.
    rem_diff = rem_sh[W-1:0] - opnd;

    acc_step = acc;
    if (is_div)
      acc_step = {(rem_ge ? rem_diff : rem_sh[W-1:0]), acc[W-2:0], rem_ge};
    else if (acc[0])
      acc_step = {mul_sum, acc[W-1:1]};
    else
      acc_step = {1'b0, acc[2*W-1:1]};

    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !cancel) begin
            state  <= RUN;
            busy   <= 1'b1;
            count  <= '0;
            is_div <= op[1];
            neg_q  <= sgn & (a[W-1] ^ b[W-1]);
            neg_r  <= sgn & a[W-1];
            acc    <= {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
            opnd   <= op[1] ? mag_b : mag_a;
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (count == LAST) state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv (W=32): directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start, cancel, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv #(.W(W), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [31:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    model = '0;
    case (o)
      2'b00: begin p = sx * sy; model = p; end
      2'b01: model = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) model = {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
        else begin
          p = sx / sy; q = p[31:0];
          p = sx % sy; r = p[31:0];
          model = {r, q};
        end
      end
      default: begin
        if (y == 0) model = {x, 32'hFFFF_FFFF};
        else model = {x % y, x / y};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge until done, bounded.
  task automatic wait_done(output int cyc, output bit got, output logic [31:0] h, output logic [31:0] l);
    cyc = 0; got = 1'b0; h = 'x; l = 'x;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b1) cyc++;
      if (done === 1'b1) begin
        got = 1'b1; h = hi; l = lo;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output bit got, output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    start_op(o, x, y);
    wait_done(cyc, got, h, l);
  endtask

  task automatic test_reset;
    int cyc; bit got; logic [31:0] h, l;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done} !== {64'h0, 2'b00}) begin
      errors++; $display("FAIL reset_init got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL reset_preload got hi=%h lo=%h want a5a5a5a5", hi, lo);
    end
    start_op(2'b01, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({hi, lo, busy, done} !== {64'h0, 2'b00}) begin
      errors++; $display("FAIL reset_mid_run got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
    end
    run_op(2'b11, 32'd100, 32'd7, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'd2 || l !== 32'd14 || cyc != W + 1) begin
      errors++; $display("FAIL reset_restart got hi=%h lo=%h cyc=%0d done=%b want hi=2 lo=e cyc=%0d", h, l, cyc, got, W + 1);
    end
  endtask

  task automatic test_mult;
    int cyc; bit got; logic [31:0] h, l;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1 || cyc != W + 1) begin
      errors++; $display("FAIL mult_neg got hi=%h lo=%h cyc=%0d done=%b want ffffffff fffffff1 cyc=%0d", h, l, cyc, got, W + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit got; logic [31:0] h, l;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'hFFFF_FFFE || l !== 32'h0000_0001 || cyc != W + 1) begin
      errors++; $display("FAIL multu_max got hi=%h lo=%h cyc=%0d done=%b want fffffffe 00000001", h, l, cyc, got);
    end
    // Start lands in the done cycle.
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(cyc, got, h, l);
    checks++;
    if (!got || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD || cyc != W + 1) begin
      errors++; $display("FAIL div_neg7_2 got hi=%h lo=%h cyc=%0d done=%b want ffffffff fffffffd", h, l, cyc, got);
    end
  endtask

  task automatic test_div;
    int cyc; bit got; logic [31:0] h, l;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'h0 || l !== 32'h8000_0000 || cyc != W + 1) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h cyc=%0d want 0 80000000", h, l, cyc);
    end
    run_op(2'b11, 32'd7, 32'd0, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'd7 || l !== 32'hFFFF_FFFF || cyc != W + 1) begin
      errors++; $display("FAIL divu_by_zero got hi=%h lo=%h cyc=%0d want 7 ffffffff", h, l, cyc);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'hFFFF_FFF9 || l !== 32'd1 || cyc != W + 1) begin
      errors++; $display("FAIL div_by_zero_neg got hi=%h lo=%h cyc=%0d want fffffff9 1", h, l, cyc);
    end
    run_op(2'b10, 32'd9, 32'd0, cyc, got, h, l);
    checks++;
    if (!got || h !== 32'd9 || l !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_by_zero_pos got hi=%h lo=%h want 9 ffffffff", h, l);
    end
  endtask

  task automatic test_cancel_mt;
    int cyc; bit got; int ndone; logic [31:0] h, l;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
      errors++; $display("FAIL mt_preload got hi=%h lo=%h want 12345678", hi, lo);
    end
    start_op(2'b01, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
      errors++; $display("FAIL cancel_run got busy=%b done=%b hi=%h lo=%h want 0 0 12345678", busy, done, hi, lo);
    end
    // Start together with cancel in idle must be dropped.
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0 || hi !== 32'h1234_5678) begin
      errors++; $display("FAIL cancel_idle got activity=%0d hi=%h want 0 12345678", ndone, hi);
    end
    // MTHI while busy is ignored; a start while busy is ignored.
    start_op(2'b11, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    start = 1'b1; op = 2'b00; a = 32'd11; b = 32'd13;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi_busy got hi=%h want 12345678", hi);
    end
    wait_done(cyc, got, h, l);
    checks++;
    if (!got || h !== 32'd2 || l !== 32'd14) begin
      errors++; $display("FAIL start_while_busy got hi=%h lo=%h want 2 e", h, l);
    end
    // MTHI/MTLO in the accepting edge, then overwritten by the result.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_FFFF;
    start_op(2'b01, 32'd6, 32'd7);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_FFFF || lo !== 32'h0000_FFFF) begin
      errors++; $display("FAIL mt_with_start got hi=%h lo=%h want 0000ffff", hi, lo);
    end
    wait_done(cyc, got, h, l);
    checks++;
    if (!got || h !== 32'd0 || l !== 32'd42) begin
      errors++; $display("FAIL mt_overwrite got hi=%h lo=%h want 0 2a", h, l);
    end
  endtask

  task automatic test_random;
    int cyc; bit got; logic [31:0] h, l, x, y;
    logic [1:0] o;
    logic [63:0] exp;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 15));
        1: x = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        2: y = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = model(o, x, y);
      run_op(o, x, y, cyc, got, h, l);
      checks++;
      if (!got || {h, l} !== exp || cyc != W + 1) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h got hi=%h lo=%h cyc=%0d want hi=%h lo=%h cyc=%0d",
                 o, x, y, h, l, cyc, exp[63:32], exp[31:0], W + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_cancel_mt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
